mem_sense_buffer: RTL and testbench

Memory data buffer directly downstream of the memory timing block. On each read strobe it captures the 28-bit core sense word and checks odd parity per syllable. It then serialises the selected syllable, or the full data word, to the CPU one bit per bit-time strobe. Because the core read is destructive, it regenerates the word (read: recirculated; store: replaced by serial CPU data) and drives the inhibit lines during the INHBS write phase.

---
 rtl/mem_sense_buffer.sv | 187 ++++++++++++++++++
 tb/tb_mem_sense_buffer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_sense_buffer.sv
// mem_sense_buffer: core memory data buffer between the sense amps and the CPU.
// A read strobe captures the 28-bit sense word and checks odd parity per
// syllable. The selected field is then shifted out serially, one bit per
// BIT_STB, LSB first. Because the core read is destructive, the field is
// regenerated while it shifts: read cycles recirculate the emitted bit and
// store cycles take SER_IN. The word is then written back through the inhibit
// drivers during INHBS.
//
// Optional build macro: MEMBUF_PARITY_INJECT_EN adds input PINJ. PINJ is
// sampled with RD, and when it is set every regenerated parity bit is inverted.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no word held; waiting for RD
// SHIFT    | word captured; shifting the selected field on BIT_STB
// WAIT_INH | field regenerated, parity rebuilt; waiting for INHBS
// DRIVE    | inhibit drivers follow ~word while INHBS is high

module mem_sense_buffer #(
  parameter  int SYL_W = 13,
  localparam int WW    = 2 * (SYL_W + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          RD,
  input  logic          INHBS,
  input  logic          SYL0N,
  input  logic          SYL1N,
  input  logic          BIT_STB,
  input  logic          WR,
  input  logic          SER_IN,
`ifdef MEMBUF_PARITY_INJECT_EN
  input  logic          PINJ,
`endif
  input  logic [WW-1:0] SENSE,
  output logic          SER_OUT,
  output logic          SER_VALID,
  output logic [WW-1:0] INH,
  output logic          BUSY,
  output logic [1:0]    PERR,
  output logic          SELERR,
  output logic          OVR
);

  localparam int CW = $clog2(2 * SYL_W + 1);

  localparam logic [1:0] MODE_SYL0 = 2'd0;
  localparam logic [1:0] MODE_SYL1 = 2'd1;
  localparam logic [1:0] MODE_FULL = 2'd2;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_INH, DRIVE} state_t;

  state_t              state, state_nxt;
  logic [WW-1:0]       data_q;
  logic [CW-1:0]       cnt_q;
  logic                wr_q;
  logic [1:0]          mode_q;
  logic                inj;

  logic [SYL_W-1:0]    s0_w, s1_w;
  logic [2*SYL_W-1:0]  full_w, full_sh;
  logic                emit, fill, last_stb;
  logic [WW-1:0]       data_sh, data_regen;
  logic [1:0]          sel_cap;
  logic [CW-1:0]       n_cap;

`ifdef MEMBUF_PARITY_INJECT_EN
  logic pinj_q;
  assign inj = pinj_q;
`else
  assign inj = 1'b0;
`endif

  // Shift and regenerate the selected field; parity of the touched syllables is rebuilt on the last strobe
  always_comb begin
    s0_w    = data_q[SYL_W-1:0];
    s1_w    = data_q[2*SYL_W:SYL_W+1];
    full_w  = {s1_w, s0_w};
    emit    = (mode_q == MODE_SYL1) ? s1_w[0] : s0_w[0];
    fill    = wr_q ? SER_IN : emit;
    full_sh = {fill, full_w[2*SYL_W-1:1]};
    data_sh = data_q;
    case (mode_q)
      MODE_SYL1: data_sh[2*SYL_W:SYL_W+1] = {fill, s1_w[SYL_W-1:1]};
      MODE_FULL: begin
        data_sh[2*SYL_W:SYL_W+1] = full_sh[2*SYL_W-1:SYL_W];
        data_sh[SYL_W-1:0]       = full_sh[SYL_W-1:0];
      end
      default:   data_sh[SYL_W-1:0] = {fill, s0_w[SYL_W-1:1]};
    endcase
    data_regen = data_sh;
    if (mode_q != MODE_SYL1) data_regen[SYL_W]  = ~(^data_sh[SYL_W-1:0]) ^ inj;
    if (mode_q != MODE_SYL0) data_regen[WW-1]   = ~(^data_sh[2*SYL_W:SYL_W+1]) ^ inj;
    last_stb = BIT_STB && (cnt_q == CW'(1));
  end

  // Decode the syllable selects at capture; both-high falls back to syllable 0
  always_comb begin
    case ({SYL1N, SYL0N})
      2'b01:   sel_cap = MODE_SYL1;
      2'b00:   sel_cap = MODE_FULL;
      default: sel_cap = MODE_SYL0;
    endcase
    n_cap = (sel_cap == MODE_FULL) ? CW'(2 * SYL_W) : CW'(SYL_W);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (RD)       state_nxt = SHIFT;
      SHIFT:    if (last_stb) state_nxt = WAIT_INH;
      WAIT_INH: if (INHBS)    state_nxt = DRIVE;
      DRIVE:    if (!INHBS)   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_q    <= '0;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      mode_q    <= MODE_SYL0;
      SER_OUT   <= 1'b0;
      SER_VALID <= 1'b0;
      INH       <= '0;
      BUSY      <= 1'b0;
      PERR      <= 2'b00;
      SELERR    <= 1'b0;
      OVR       <= 1'b0;
`ifdef MEMBUF_PARITY_INJECT_EN
      pinj_q    <= 1'b0;
`endif
    end else begin
      SER_OUT   <= 1'b0;
      SER_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (RD) begin
            data_q <= SENSE;
            wr_q   <= WR;
            mode_q <= sel_cap;
            cnt_q  <= n_cap;
            PERR   <= {~(^SENSE[WW-1:SYL_W+1]), ~(^SENSE[SYL_W:0])};
            BUSY   <= 1'b1;
            if (SYL0N && SYL1N) SELERR <= 1'b1;
`ifdef MEMBUF_PARITY_INJECT_EN
            pinj_q <= PINJ;
`endif
          end
        end
        SHIFT: begin
          if (RD) OVR <= 1'b1;
          if (BIT_STB) begin
            SER_VALID <= 1'b1;
            SER_OUT   <= emit;
            cnt_q     <= cnt_q - CW'(1);
            data_q    <= last_stb ? data_regen : data_sh;
          end
        end
        WAIT_INH: begin
          if (RD)    OVR <= 1'b1;
          if (INHBS) INH <= ~data_q;
        end
        DRIVE: begin
          if (RD) OVR <= 1'b1;
          if (INHBS) begin
            INH <= ~data_q;
          end else begin
            INH  <= '0;
            BUSY <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sense_buffer.sv
// Bench for mem_sense_buffer: directed vectors with hand-computed status and
// inhibit values. Expected serial bits are queued at capture, and a negedge
// monitor pops and compares them whenever SER_VALID is high.

module tb_mem_sense_buffer;
  localparam int SYL_W = 13;
  localparam int WW    = 28;

  logic          CLK = 1'b0;
  logic          RESET, RD, INHBS, SYL0N, SYL1N, BIT_STB, WR, SER_IN;
  logic [WW-1:0] SENSE;
  logic          SER_OUT, SER_VALID, BUSY, SELERR, OVR;
  logic [WW-1:0] INH;
  logic [1:0]    PERR;
`ifdef MEMBUF_PARITY_INJECT_EN
  logic          PINJ = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  bit mon_exp;

  typedef struct {
    logic [WW-1:0] sense;
    logic          s0n, s1n, wr, ser;
    int            nbits;
    logic [1:0]    perr;
    logic          selerr;
    logic [WW-1:0] inh;
    int            ovr_at;
  } vec_t;

  vec_t vecs[8];

  always #5 CLK = ~CLK;

  mem_sense_buffer #(.SYL_W(SYL_W)) dut (
    .CLK(CLK), .RESET(RESET), .RD(RD), .INHBS(INHBS), .SYL0N(SYL0N),
    .SYL1N(SYL1N), .BIT_STB(BIT_STB), .WR(WR), .SER_IN(SER_IN),
`ifdef MEMBUF_PARITY_INJECT_EN
    .PINJ(PINJ),
`endif
    .SENSE(SENSE), .SER_OUT(SER_OUT), .SER_VALID(SER_VALID), .INH(INH),
    .BUSY(BUSY), .PERR(PERR), .SELERR(SELERR), .OVR(OVR)
  );

  // Serial monitor: every SER_VALID cycle must match the next queued bit
  always @(negedge CLK) begin
    if (SER_VALID) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ser_extra: SER_OUT=%b presented, no bit expected", SER_OUT);
      end else begin
        mon_exp = exp_q.pop_front();
        if (SER_OUT !== mon_exp) begin
          errors++;
          $display("FAIL ser_bit: got %b expected %b", SER_OUT, mon_exp);
        end
      end
    end
  end

  task automatic check(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic bit field_bit(logic [WW-1:0] s, logic s0n, logic s1n, int i);
    if (!s0n && !s1n) return (i < SYL_W) ? s[i] : s[i+1];
    if (s0n && !s1n)  return s[SYL_W+1+i];
    return s[i];
  endfunction

  task automatic capture(vec_t v, int nexp);
    RD = 1'b1; SENSE = v.sense; SYL0N = v.s0n; SYL1N = v.s1n; WR = v.wr;
    for (int i = 0; i < nexp; i++) exp_q.push_back(field_bit(v.sense, v.s0n, v.s1n, i));
    cyc(1);
    RD = 1'b0; SENSE = WW'($urandom); SYL0N = 1'b1; SYL1N = 1'b1; WR = 1'b0;
  endtask

  task automatic strobe(logic ser);
    BIT_STB = 1'b1; SER_IN = ser;
    cyc(1);
    BIT_STB = 1'b0; SER_IN = 1'b0;
    cyc(1);
  endtask

  task automatic run_vec(vec_t v, string tag);
    capture(v, v.nbits);
    check({tag, "_busy"},   WW'(BUSY),   WW'(1));
    check({tag, "_perr"},   WW'(PERR),   WW'(v.perr));
    check({tag, "_selerr"}, WW'(SELERR), WW'(v.selerr));
    for (int i = 0; i < v.nbits; i++) begin
      if (i == v.ovr_at) begin
        RD = 1'b1; cyc(1); RD = 1'b0;
      end
      strobe(v.ser);
    end
    strobe(1'b1);                      // stray strobe while waiting for INHBS
    check({tag, "_inh_idle"}, INH, '0);
    INHBS = 1'b1;
    cyc(1);
    check({tag, "_inh"}, INH, v.inh);
    cyc(2);
    check({tag, "_inh_hold"}, INH, v.inh);
    INHBS = 1'b0;
    cyc(1);
    check({tag, "_busy_end"}, WW'(BUSY), WW'(0));
    check({tag, "_inh_end"},  INH, '0);
  endtask

  initial begin
    //          sense         s0n   s1n   wr    ser   n   perr   selerr inh          ovr_at
    vecs[0] = '{28'h0002AAA, 1'b0, 1'b1, 1'b0, 1'b0, 13, 2'b10, 1'b0, 28'hFFFD555, -1}; // syl1 half all zero: even
    vecs[1] = '{28'h0000000, 1'b1, 1'b0, 1'b1, 1'b1, 13, 2'b11, 1'b0, 28'h8003FFF, -1}; // store 1s into syl1
    vecs[2] = '{28'h0004001, 1'b0, 1'b0, 1'b0, 1'b0, 26, 2'b00, 1'b0, 28'hFFFBFFE, -1}; // full word restore
    vecs[3] = '{28'h0006001, 1'b0, 1'b1, 1'b0, 1'b0, 13, 2'b01, 1'b0, 28'hFFFBFFE, -1}; // bad syl0 parity, rebuilt
    vecs[4] = '{28'h0004001, 1'b0, 1'b1, 1'b0, 1'b0, 13, 2'b00, 1'b0, 28'hFFFBFFE, -1}; // clean read clears PERR
    vecs[5] = '{28'h0004001, 1'b0, 1'b0, 1'b1, 1'b0, 26, 2'b00, 1'b0, 28'h7FFDFFF, -1}; // store zeros, full word
    vecs[6] = '{28'h0002AAA, 1'b1, 1'b1, 1'b0, 1'b0, 13, 2'b10, 1'b1, 28'hFFFD555, -1}; // both selects high
    vecs[7] = '{28'h0004001, 1'b1, 1'b0, 1'b0, 1'b0, 13, 2'b00, 1'b1, 28'hFFFBFFE,  3}; // RD during SHIFT

    RESET = 1'b1; RD = 1'b0; INHBS = 1'b0; SYL0N = 1'b1; SYL1N = 1'b1;
    BIT_STB = 1'b0; WR = 1'b0; SER_IN = 1'b0; SENSE = '0;
    cyc(2);
    check("rst_busy", WW'(BUSY), WW'(0));
    check("rst_inh", INH, '0);
    check("rst_perr", WW'(PERR), WW'(0));
    check("rst_flags", WW'({SELERR, OVR, SER_VALID, SER_OUT}), WW'(0));
    RESET = 1'b0;
    cyc(1);

    INHBS = 1'b1;                      // INHBS in IDLE must not drive
    cyc(2);
    check("idle_inhbs_inh", INH, '0);
    check("idle_inhbs_busy", WW'(BUSY), WW'(0));
    INHBS = 1'b0;
    cyc(1);

    run_vec(vecs[0], "rd_syl0");
    run_vec(vecs[1], "st_syl1");
    run_vec(vecs[2], "rd_full");
    run_vec(vecs[3], "perr_bad");
    run_vec(vecs[4], "perr_clr");
    run_vec(vecs[5], "st_full");
    run_vec(vecs[6], "sel_both");
    check("ovr_before", WW'(OVR), WW'(0));
    run_vec(vecs[7], "ovr");
    check("ovr_after", WW'(OVR), WW'(1));

    // Reset after 5 strobes of a syl0 read; only those 5 bits are expected
    capture(vecs[0], 5);
    for (int i = 0; i < 5; i++) strobe(1'b0);
    RESET = 1'b1;
    cyc(1);
    check("midrst_busy", WW'(BUSY), WW'(0));
    check("midrst_inh", INH, '0);
    check("midrst_perr", WW'(PERR), WW'(0));
    check("midrst_flags", WW'({SELERR, OVR, SER_VALID}), WW'(0));
    RESET = 1'b0;
    cyc(1);
    run_vec(vecs[0], "post_rst");
    check("post_rst_ovr", WW'(OVR), WW'(0));

    cyc(2);
    check("sb_empty", WW'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
